// File: rtl/pipe_hazard_ctrl.sv
// Interlock/sequencing controller for the 5-stage MIPS32 pipeline: destination scoreboard,
// RAW stall, branch squash and HLT drain. Optional forwarding mode under PIPE_HAZ_FWD_EN.
module pipe_hazard_ctrl #(
    parameter int DEPTH = 3,
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_load,
    input  logic             id_hlt,
    input  logic             ex_br_taken,
    output logic             stall,
    output logic             flush,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
`ifdef PIPE_HAZ_FWD_EN
    ,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
`endif
);

    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] load_reg;
    logic [REG_W-1:0] rd_reg [DEPTH];
    logic             halt_pend_reg;
    logic             halted_reg;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [DEPTH-1:0] match_rs;
    logic [DEPTH-1:0] match_rt;
    logic             hazard;
    logic             push_valid;

    // R0 is hardwired zero, so it never creates a dependency.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match_rs[gi] = valid_reg[gi] && (rd_reg[gi] == id_rs) && (id_rs != '0) && id_use_rs;
            assign match_rt[gi] = valid_reg[gi] && (rd_reg[gi] == id_rt) && (id_rt != '0) && id_use_rt;
        end
    endgenerate

`ifdef PIPE_HAZ_FWD_EN
    // Only a load still in EX cannot be bypassed; everything else forwards.
    assign hazard = (match_rs[0] || match_rt[0]) && load_reg[0];

    // Walk oldest to youngest so the youngest match overrides.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i < 3 && match_rs[i]) fwd_a = 2'(i + 1);
            if (i < 3 && match_rt[i]) fwd_b = 2'(i + 1);
        end
    end
`else
    assign hazard = |(match_rs | match_rt);
    logic unused_load;
    assign unused_load = ^load_reg;
`endif

    assign flush      = ex_br_taken;
    assign stall      = id_valid && !ex_br_taken && !halted_reg && hazard;
    assign pc_en      = !stall && !halt_pend_reg && !halted_reg;
    assign ifid_en    = pc_en;
    assign halted     = halted_reg;
    assign stall_cnt  = stall_cnt_reg;
    assign push_valid = id_valid && id_wr && (id_rd != '0) && !stall && !flush;

    always_ff @(posedge clk1) begin
        if (rst) begin
            valid_reg     <= '0;
            load_reg      <= '0;
            for (int i = 0; i < DEPTH; i++) rd_reg[i] <= '0;
            halt_pend_reg <= 1'b0;
            halted_reg    <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                valid_reg[i] <= valid_reg[i-1];
                rd_reg[i]    <= rd_reg[i-1];
                load_reg[i]  <= load_reg[i-1];
            end
            valid_reg[0] <= push_valid;
            rd_reg[0]    <= id_rd;
            load_reg[0]  <= id_load;

            if (stall && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + 1'b1;

            // Halt completes only once every in-flight writer has retired.
            if (halted_reg) begin
                halt_pend_reg <= 1'b0;
            end else if (halt_pend_reg && valid_reg == '0) begin
                halted_reg    <= 1'b1;
                halt_pend_reg <= 1'b0;
            end else if (id_valid && id_hlt && !flush && !stall) begin
                halt_pend_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: issue-history reference model plus directed literals.
module tb_pipe_hazard_ctrl;
    localparam int DEPTH = 3;
    localparam int REG_W = 5;
    localparam int CNT_W = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk1 = 1'b0;
    logic rst, id_valid, id_use_rs, id_use_rt, id_wr, id_load, id_hlt, ex_br_taken;
    logic [REG_W-1:0] id_rs, id_rt, id_rd;
    logic stall, flush, pc_en, ifid_en, halted;
    logic [CNT_W-1:0] stall_cnt;
`ifdef PIPE_HAZ_FWD_EN
    logic [1:0] fwd_a, fwd_b;
`endif

    pipe_hazard_ctrl #(.DEPTH(DEPTH), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk1(clk1), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_rd(id_rd),
        .id_load(id_load), .id_hlt(id_hlt), .ex_br_taken(ex_br_taken),
        .stall(stall), .flush(flush), .pc_en(pc_en), .ifid_en(ifid_en),
        .halted(halted), .stall_cnt(stall_cnt)
`ifdef PIPE_HAZ_FWD_EN
        , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
    );

    always #5 clk1 = ~clk1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: destinations issued in the last DEPTH cycles (0 = nothing written).
    int q_rd[$];
    int q_ld[$];
    bit m_hpend, m_halted;
    int m_cnt;

    // Values sampled in the last cycle, for the directed literal checks.
    logic smp_stall, smp_flush, smp_pc, smp_halted;
    logic [CNT_W-1:0] smp_cnt;
    logic [1:0] smp_fa, smp_fb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    function automatic bit pending(int r);
        if (r == 0) return 1'b0;
        foreach (q_rd[k]) if (q_rd[k] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int fwd_sel(int r, bit use_r);
        if (!use_r || r == 0) return 0;
        for (int k = 0; k < DEPTH && k < 3; k++) if (q_rd[k] == r) return k + 1;
        return 0;
    endfunction

    task automatic model_reset();
        q_rd.delete(); q_ld.delete();
        for (int k = 0; k < DEPTH; k++) begin q_rd.push_back(0); q_ld.push_back(0); end
        m_hpend = 0; m_halted = 0; m_cnt = 0;
    endtask

    task automatic drive(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                         input bit wr, input int rd, input bit ld, input bit hlt, input bit br);
        id_valid = v; id_rs = REG_W'(rs); id_use_rs = urs; id_rt = REG_W'(rt); id_use_rt = urt;
        id_wr = wr; id_rd = REG_W'(rd); id_load = ld; id_hlt = hlt; ex_br_taken = br;
    endtask

    // One transaction: compare outputs against the model mid-cycle, then advance the model.
    task automatic cycle();
        bit e_stall, haz, all_empty;
        int w;
        #3;
`ifdef PIPE_HAZ_FWD_EN
        haz = (id_use_rs && id_rs != 0 && q_rd[0] == int'(id_rs) && q_ld[0] != 0) ||
              (id_use_rt && id_rt != 0 && q_rd[0] == int'(id_rt) && q_ld[0] != 0);
`else
        haz = (id_use_rs && pending(int'(id_rs))) || (id_use_rt && pending(int'(id_rt)));
`endif
        e_stall = id_valid && !ex_br_taken && !m_halted && haz;
        smp_stall = stall; smp_flush = flush; smp_pc = pc_en; smp_halted = halted; smp_cnt = stall_cnt;
        check("stall", 32'(stall), 32'(e_stall));
        check("flush", 32'(flush), 32'(ex_br_taken));
        check("pc_en", 32'(pc_en), 32'(!e_stall && !m_hpend && !m_halted));
        check("ifid_en", 32'(ifid_en), 32'(!e_stall && !m_hpend && !m_halted));
        check("halted", 32'(halted), 32'(m_halted));
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
`ifdef PIPE_HAZ_FWD_EN
        smp_fa = fwd_a; smp_fb = fwd_b;
        check("fwd_a", 32'(fwd_a), 32'(fwd_sel(int'(id_rs), id_use_rs)));
        check("fwd_b", 32'(fwd_b), 32'(fwd_sel(int'(id_rt), id_use_rt)));
`else
        smp_fa = 2'b00; smp_fb = 2'b00;
`endif
        $display("cyc %0d rst=%0d v=%0d rs=%0d rt=%0d rd=%0d wr=%0d hlt=%0d br=%0d stall=%0d flush=%0d pc_en=%0d halted=%0d cnt=%0d",
                 cyc, rst, id_valid, id_rs, id_rt, id_rd, id_wr, id_hlt, ex_br_taken,
                 stall, flush, pc_en, halted, stall_cnt);
        if (rst) begin
            model_reset();
        end else begin
            all_empty = 1;
            foreach (q_rd[k]) if (q_rd[k] != 0) all_empty = 0;
            if (!m_halted) begin
                if (m_hpend && all_empty) begin m_halted = 1; m_hpend = 0; end
                else if (id_valid && id_hlt && !ex_br_taken && !e_stall) m_hpend = 1;
            end
            if (e_stall && m_cnt != CNT_MAX) m_cnt++;
            w = (id_valid && id_wr && !e_stall && !ex_br_taken) ? int'(id_rd) : 0;
            q_rd.push_front(w); void'(q_rd.pop_back());
            q_ld.push_front(int'(id_load)); void'(q_ld.pop_back());
        end
        @(posedge clk1); #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin drive(0,0,0,0,0,0,0,0,0,0); cycle(); end
    endtask

    initial begin
        rst = 1'b1;
        drive(0,0,0,0,0,0,0,0,0,0);
        model_reset();
        @(posedge clk1); #1;
        rst = 1'b0;

        // Reset state
        cycle();
        check("rst_stall", 32'(smp_stall), 32'd0);
        check("rst_pc_en", 32'(smp_pc), 32'd1);
        check("rst_halted", 32'(smp_halted), 32'd0);
        check("rst_cnt", 32'(smp_cnt), 32'd0);

        // Back-to-back dependency on R7
        drive(1,0,0,0,0,1,7,0,0,0); cycle();
        drive(1,7,1,0,0,1,8,0,0,0);
`ifndef PIPE_HAZ_FWD_EN
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("b2b_stall", 32'(smp_stall), 32'd1);
            check("b2b_pc_en", 32'(smp_pc), 32'd0);
        end
        cycle();
        check("b2b_release", 32'(smp_stall), 32'd0);
        check("b2b_cnt", 32'(smp_cnt), 32'd3);
`else
        cycle();
        check("fwd_b2b_stall", 32'(smp_stall), 32'd0);
        check("fwd_b2b_a", 32'(smp_fa), 32'd1);
`endif

        // R0 writer followed by R0 readers
        drive(1,0,0,0,0,1,0,0,0,0); cycle();
        drive(1,0,1,0,1,0,0,0,0,0); cycle();
        check("r0_stall", 32'(smp_stall), 32'd0);

        // Taken branch overrides a slot1 hazard and pushes a bubble
        drive(1,0,0,0,0,1,9,0,0,0); cycle();
        drive(1,0,0,0,0,0,0,0,0,0); cycle();
        drive(1,9,1,0,0,1,4,0,0,1); cycle();
        check("br_flush", 32'(smp_flush), 32'd1);
        check("br_stall", 32'(smp_stall), 32'd0);
        drive(1,4,1,0,0,0,0,0,0,0); cycle();
        check("br_bubble", 32'(smp_stall), 32'd0);

        // HLT behind an in-flight LW R5
        idle(3);
        drive(1,0,0,0,0,1,5,1,0,0); cycle();
        drive(1,0,0,0,0,0,0,0,1,0); cycle();
        check("hlt_issue_pc", 32'(smp_pc), 32'd1);
        cycle();
        check("hlt_freeze_pc", 32'(smp_pc), 32'd0);
        cycle();
        cycle();
        check("hlt_not_yet", 32'(smp_halted), 32'd0);
        cycle();
        check("hlt_halted", 32'(smp_halted), 32'd1);
        drive(1,3,1,3,1,1,3,0,0,0); cycle(); cycle();
        check("hlt_sticky", 32'(smp_halted), 32'd1);
        check("hlt_pc_low", 32'(smp_pc), 32'd0);

        // Reset in the middle of a stall
        rst = 1'b1; drive(0,0,0,0,0,0,0,0,0,0); cycle(); rst = 1'b0;
        drive(1,0,0,0,0,1,7,0,0,0); cycle();
        drive(1,7,1,0,0,0,0,0,0,0); cycle(); cycle(); cycle();
`ifndef PIPE_HAZ_FWD_EN
        check("mid_stall", 32'(smp_stall), 32'd1);
        check("mid_cnt", 32'(smp_cnt), 32'd2);
`endif
        rst = 1'b1; cycle(); rst = 1'b0;
        cycle();
        check("post_rst_stall", 32'(smp_stall), 32'd0);
        check("post_rst_cnt", 32'(smp_cnt), 32'd0);
        check("post_rst_pc", 32'(smp_pc), 32'd1);

`ifdef PIPE_HAZ_FWD_EN
        // Load-use: one stall, then forward from MEM/WB
        drive(1,0,0,0,0,1,5,1,0,0); cycle();
        drive(1,0,0,5,1,1,6,0,0,0); cycle();
        check("lu_stall", 32'(smp_stall), 32'd1);
        cycle();
        check("lu_release", 32'(smp_stall), 32'd0);
        check("lu_fwd_b", 32'(smp_fb), 32'd2);
        drive(1,0,0,0,0,1,10,0,0,0); cycle();
        drive(1,10,1,0,0,0,0,0,0,0); cycle();
        check("alu_stall", 32'(smp_stall), 32'd0);
        check("alu_fwd_a", 32'(smp_fa), 32'd1);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(63) == 0);
            drive($urandom_range(3) != 0, $urandom_range(7), $urandom_range(1), $urandom_range(7),
                  $urandom_range(1), $urandom_range(1), $urandom_range(7), $urandom_range(2) == 0,
                  $urandom_range(39) == 0, $urandom_range(7) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
